// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Byte-wide UART transmitter fed by a small synchronous frame FIFO.
//   Bytes are accepted on a valid/ready handshake, queued first-in
//   first-out, and serialised as 1 start bit (0), PAYLOAD_BITS data bits
//   LSB first and 1 stop bit (1), with no parity. Each line bit lasts
//   CLK_HZ/BIT_RATE clocks. Back-to-back frames are sent with no idle gap.
//
// Ports
//   clk         in   single clock, rising edge
//   reset       in   asynchronous, active-high reset
//   s_data      in   byte to enqueue
//   s_valid     in   s_data is valid this cycle
//   s_ready     out  FIFO has room; a push happens when s_valid && s_ready
//   uart_txd    out  registered serial line, idles high
//   tx_busy     out  serializer is sending a frame
//   fifo_level  out  number of queued bytes, 0..FIFO_DEPTH

module uart_tx_fifo #(
  parameter int CLK_HZ       = 100000000,
  parameter int BIT_RATE     = 115200,
  parameter int PAYLOAD_BITS = 8,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [PAYLOAD_BITS-1:0]       s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          uart_txd,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam int IW = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;

  localparam logic [AW:0]   LEVEL_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   LEVEL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LEVEL_ZERO = '0;
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(CYCLES_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(PAYLOAD_BITS - 1);
  localparam logic [IW-1:0] IDX_ONE    = IW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } txState_e;

  // FIFO storage and bookkeeping
  logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]           wrPtr_q, wrPtr_d;
  logic [AW-1:0]           rdPtr_q, rdPtr_d;
  logic [AW:0]             level_q, level_d;

  // Serializer registers
  txState_e                state_q;
  logic [CW-1:0]           baudCnt_q;
  logic [IW-1:0]           bitIdx_q;
  logic [PAYLOAD_BITS-1:0] shift_q;
  logic                    txd_q;
  logic                    busy_q;

  logic                    push;
  logic                    pop;
  logic                    bitDone;
  logic [PAYLOAD_BITS-1:0] headData;

  assign s_ready    = (level_q < LEVEL_FULL);
  assign push       = s_valid && s_ready;
  assign bitDone    = (baudCnt_q == CNT_LAST);
  assign headData   = mem[rdPtr_q];

  // A frame is fetched from IDLE, or at the very end of a stop bit so the
  // next start bit follows with no idle gap. Both cases need a non-empty
  // FIFO as seen before the edge.
  assign pop = (level_q != LEVEL_ZERO) &&
               ((state_q == IDLE) || ((state_q == STOP) && bitDone));

  assign uart_txd   = txd_q;
  assign tx_busy    = busy_q;
  assign fifo_level = level_q;

  // Next-state pointers and occupancy; a push and pop on the same edge
  // cancel out in the level while both pointers still advance.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;
    if (push) begin
      wrPtr_d = wrPtr_q + PTR_ONE;
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LEVEL_ONE;
      2'b01:   level_d = level_q - LEVEL_ONE;
      default: level_d = level_q;
    endcase
  end

  // FIFO pointer/level registers; reset empties the queue, stale memory
  // contents are simply never read again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      level_q <= level_d;
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr_q] <= s_data;
    end
  end

  // Serializer FSM with registered line and busy outputs. The baud counter
  // runs 0..CYCLES_PER_BIT-1 in every non-idle state; each state change
  // drives the first line value of the new bit on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      baudCnt_q <= '0;
      bitIdx_q  <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          txd_q     <= 1'b1;
          busy_q    <= 1'b0;
          baudCnt_q <= '0;
          if (pop) begin
            shift_q <= headData;
            state_q <= START;
            txd_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end

        START: begin
          if (bitDone) begin
            baudCnt_q <= '0;
            bitIdx_q  <= '0;
            txd_q     <= shift_q[0];
            shift_q   <= shift_q >> 1;
            state_q   <= DATA;
          end else begin
            baudCnt_q <= baudCnt_q + CNT_ONE;
          end
        end

        DATA: begin
          if (bitDone) begin
            baudCnt_q <= '0;
            if (bitIdx_q == IDX_LAST) begin
              txd_q   <= 1'b1;
              state_q <= STOP;
            end else begin
              bitIdx_q <= bitIdx_q + IDX_ONE;
              txd_q    <= shift_q[0];
              shift_q  <= shift_q >> 1;
            end
          end else begin
            baudCnt_q <= baudCnt_q + CNT_ONE;
          end
        end

        STOP: begin
          if (bitDone) begin
            baudCnt_q <= '0;
            if (pop) begin
              shift_q <= headData;
              txd_q   <= 1'b0;
              state_q <= START;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else begin
            baudCnt_q <= baudCnt_q + CNT_ONE;
          end
        end

        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//   Directed bench for uart_tx_fifo at CLK_HZ=1000, BIT_RATE=300, so each
//   line bit is 3 clocks and a frame is 30 clocks. A monitor logs uart_txd
//   once per clock; frames are pulled out of the log at known start indices
//   and compared against the expected 30-sample line pattern.

module tb_uart_tx_fifo;

  localparam int CPB   = 3;
  localparam int FRAME = 30;

  logic       clk;
  logic       reset;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       uart_txd;
  logic       tx_busy;
  logic [4:0] fifo_level;

  int checkCount = 0;
  int errorCount = 0;

  logic lineLog[$];

  uart_tx_fifo #(
    .CLK_HZ      (1000),
    .BIT_RATE    (300),
    .PAYLOAD_BITS(8),
    .FIFO_DEPTH  (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .uart_txd  (uart_txd),
    .tx_busy   (tx_busy),
    .fifo_level(fifo_level)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line monitor: one sample per rising edge, taken a little after the
  // point where the main thread samples, so index == edge number.
  always begin
    @(posedge clk);
    #2;
    lineLog.push_back(uart_txd);
  end

  // Safety net in case something stalls the stimulus thread.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one handshake beat across the next rising edge, then drop valid.
  task automatic applyStimulus(input logic valid, input logic [7:0] data);
    s_valid = valid;
    s_data  = data;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  // Index that the monitor will give to the sample of the current/next edge.
  function automatic int nowIdx();
    return lineLog.size();
  endfunction

  task automatic advanceTo(input int idx);
    while (nowIdx() < idx) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected line samples for one frame, sample 0 in bit 0.
  function automatic logic [31:0] expectFrame(input logic [7:0] d);
    logic [31:0] v;
    logic        bitVal;
    v = '0;
    for (int b = 0; b < 10; b++) begin
      if (b == 0)      bitVal = 1'b0;
      else if (b == 9) bitVal = 1'b1;
      else             bitVal = d[b-1];
      for (int k = 0; k < CPB; k++) v[b*CPB+k] = bitVal;
    end
    return v;
  endfunction

  function automatic logic [31:0] grabFrame(input int start);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < FRAME; i++) v[i] = lineLog[start+i];
    return v;
  endfunction

  function automatic logic [7:0] fullByte(input int i);
    return 8'((i * 29) + 7);
  endfunction

  initial begin
    int start;
    int zeros;
    logic [7:0] backBytes[3];
    logic [7:0] simBytes[5];
    backBytes = '{8'h00, 8'hFF, 8'h55};
    simBytes  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hC3};

    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'h00;

    // Reset state while reset is held.
    #2;
    checkOutput("rstTxd",   32'(uart_txd),   32'd1);
    checkOutput("rstBusy",  32'(tx_busy),    32'd0);
    checkOutput("rstLevel", 32'(fifo_level), 32'd0);
    checkOutput("rstReady", 32'(s_ready),    32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("idleTxd",  32'(uart_txd), 32'd1);
    checkOutput("idleBusy", 32'(tx_busy),  32'd0);

    // Single byte 0xA5: low from the edge after the push, 30-clock frame.
    applyStimulus(1'b1, 8'hA5);
    checkOutput("a5PushTxd",   32'(uart_txd),   32'd1);
    checkOutput("a5PushLevel", 32'(fifo_level), 32'd1);
    start = nowIdx() + 1;
    advanceTo(start);
    checkOutput("a5StartTxd",   32'(uart_txd),   32'd0);
    checkOutput("a5StartBusy",  32'(tx_busy),    32'd1);
    checkOutput("a5StartLevel", 32'(fifo_level), 32'd0);
    advanceTo(start + FRAME - 1);
    checkOutput("a5LastBusy", 32'(tx_busy), 32'd1);
    advanceTo(start + FRAME);
    checkOutput("a5Frame",    grabFrame(start), 32'h3F1C0E38);
    checkOutput("a5DoneBusy", 32'(tx_busy),  32'd0);
    checkOutput("a5DoneTxd",  32'(uart_txd), 32'd1);

    // Back-to-back pushes: frames abut, level peaks at 2.
    advanceTo(nowIdx() + 4);
    applyStimulus(1'b1, backBytes[0]);
    applyStimulus(1'b1, backBytes[1]);
    start = nowIdx();
    applyStimulus(1'b1, backBytes[2]);
    checkOutput("b2bPeakLevel", 32'(fifo_level), 32'd2);
    advanceTo(start + 3*FRAME);
    for (int f = 0; f < 3; f++)
      checkOutput($sformatf("b2bFrame%0d", f), grabFrame(start + f*FRAME),
                  expectFrame(backBytes[f]));
    checkOutput("b2bDoneBusy",  32'(tx_busy),    32'd0);
    checkOutput("b2bDoneLevel", 32'(fifo_level), 32'd0);

    // Full FIFO: 16 accepted behind an active frame, 17th dropped.
    advanceTo(nowIdx() + 4);
    applyStimulus(1'b1, 8'h3C);
    start = nowIdx() + 1;
    applyStimulus(1'b0, 8'h00);
    applyStimulus(1'b0, 8'h00);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, fullByte(i));
      if (i == 14) checkOutput("fullReadyAt15", 32'(s_ready), 32'd1);
      if (i == 15) begin
        checkOutput("fullLevel16", 32'(fifo_level), 32'd16);
        checkOutput("fullReady0",  32'(s_ready),    32'd0);
      end
    end
    checkOutput("fullLevelAfter17", 32'(fifo_level), 32'd16);
    advanceTo(start + 17*FRAME);
    checkOutput("fullFrameHead", grabFrame(start), expectFrame(8'h3C));
    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("fullFrame%0d", i), grabFrame(start + (i+1)*FRAME),
                  expectFrame(fullByte(i)));
    checkOutput("fullDoneLevel", 32'(fifo_level), 32'd0);
    advanceTo(nowIdx() + 5);
    checkOutput("fullDoneBusy", 32'(tx_busy),  32'd0);
    checkOutput("fullDoneTxd",  32'(uart_txd), 32'd1);

    // Push exactly on the STOP->START pop edge with three bytes queued.
    advanceTo(nowIdx() + 4);
    applyStimulus(1'b1, simBytes[0]);
    applyStimulus(1'b1, simBytes[1]);
    start = nowIdx();
    applyStimulus(1'b1, simBytes[2]);
    applyStimulus(1'b1, simBytes[3]);
    advanceTo(start + FRAME - 1);
    checkOutput("simLevelBefore", 32'(fifo_level), 32'd3);
    applyStimulus(1'b1, simBytes[4]);
    checkOutput("simLevelAfter", 32'(fifo_level), 32'd3);
    advanceTo(start + 5*FRAME);
    for (int f = 0; f < 5; f++)
      checkOutput($sformatf("simFrame%0d", f), grabFrame(start + f*FRAME),
                  expectFrame(simBytes[f]));
    checkOutput("simDoneBusy", 32'(tx_busy), 32'd0);

    // Reset during data bit 4 with five bytes queued.
    advanceTo(nowIdx() + 4);
    applyStimulus(1'b1, 8'h10);
    applyStimulus(1'b1, 8'h20);
    start = nowIdx();
    for (int i = 2; i < 6; i++) applyStimulus(1'b1, 8'(i * 16));
    checkOutput("rmfLevel5", 32'(fifo_level), 32'd5);
    advanceTo(start + 16);
    checkOutput("rmfBusyBit4", 32'(tx_busy), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("rmfTxd",   32'(uart_txd),   32'd1);
    checkOutput("rmfLevel", 32'(fifo_level), 32'd0);
    checkOutput("rmfBusy",  32'(tx_busy),    32'd0);
    checkOutput("rmfReady", 32'(s_ready),    32'd1);
    @(negedge clk);
    reset = 1'b0;
    start = nowIdx();
    advanceTo(start + 40);
    zeros = 0;
    for (int i = 0; i < 40; i++) if (lineLog[start+i] == 1'b0) zeros++;
    checkOutput("rmfQuietLine",  32'(zeros),      32'd0);
    checkOutput("rmfQuietBusy",  32'(tx_busy),    32'd0);
    checkOutput("rmfQuietLevel", 32'(fifo_level), 32'd0);

    // First push after reset release behaves like a fresh start.
    applyStimulus(1'b1, 8'h96);
    start = nowIdx() + 1;
    advanceTo(start);
    checkOutput("postRstStartTxd", 32'(uart_txd), 32'd0);
    advanceTo(start + FRAME);
    checkOutput("postRstFrame",    grabFrame(start), expectFrame(8'h96));
    checkOutput("postRstDoneBusy", 32'(tx_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
